romulus_ctrl: RTL and testbench
===============================

ROMULUS_CTRL -- requirements
Module: romulus_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  in  1  one-cycle request to process one block; sampled only in IDLE.
REQ-004 SHALL have ports cmd_decrypt  in  1, cmd_hash  in  1, cmd_domain  in  8  block parameters, captured when start is accepted.
REQ-005 SHALL have ports in_valid  in  1 and in_ready  out  1  handshake for 32-bit beats on pdi/sdi of the datapath.
REQ-006 SHALL have ports out_valid  out  1 and out_ready  in  1  handshake for 32-bit pdo beats.
REQ-007 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), err  out  1 (one-cycle pulse).
REQ-008 SHALL have ports srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse, erst, correct_cnt, tk1s, hash_cipher  out  1 each  datapath controls.
REQ-009 SHALL have ports constant  out  6, constant2  out  6, domain  out  8, decrypt  out  4  datapath round constants and mode fields.

Function
REQ-010 SHALL implement states IDLE, LD_S, LD_TK, RUN, OUT, CNT.
REQ-011 IDLE: start=1 -> capture cmd_*, enter LD_S; start while busy SHALL be ignored.
REQ-012 LD_S: in_ready=1; each in_valid&in_ready beat asserts sse for that cycle; after 4 beats -> LD_TK.
REQ-013 LD_TK: in_ready=1; each accepted beat asserts xse and yse together; after 4 beats -> RUN.
REQ-014 Beat counter 2 bits, wraps 3->0 on the 4th beat; no beat accepted while in_valid=0 (all *se low).
REQ-015 RUN: senc, xenc, yenc, zenc =1 for exactly 20 cycles (40 rounds, two per cycle); then -> OUT.
REQ-016 Round-constant LFSR rc (6 bits) SHALL be 0 on entering RUN; step(r) = {r[4:0], r[5]^r[4]^1}; constant=step(rc), constant2=step(step(rc)); rc<=constant2 each RUN cycle.
REQ-017 Outside RUN, constant and constant2 SHALL be 0.
REQ-018 OUT: out_valid=1; each out_valid&out_ready beat asserts sse; after 4 beats -> CNT; out_ready=0 holds state and beat count.
REQ-019 CNT: one cycle with zenc=1, correct_cnt=1; then -> IDLE with done=1 in that cycle.
REQ-020 decrypt SHALL equal {4{captured cmd_decrypt}} during OUT, else 0; domain SHALL equal captured cmd_domain while busy.
REQ-021 tk1s SHALL be 1 in CNT when captured cmd_domain[3]=1, else 0.
REQ-022 busy=1 in every state except IDLE; no-stall latency start->done = 33 cycles.
REQ-023 srst, xrst, yrst, zrst, erst SHALL pulse for one cycle on the IDLE->LD_S transition.

Reset
REQ-024 rst_n=0 SHALL force IDLE, rc=0, beat counter=0, captured fields=0, all outputs 0, asynchronously, including mid-RUN or mid-OUT.
REQ-025 After rst_n release, first accepted start SHALL behave identically to power-up.

Configuration
REQ-026 Macro ROMULUS_CTRL_HASH_EN: defined -> cmd_hash accepted, hash_cipher=captured cmd_hash during RUN, else 0.
REQ-027 Without ROMULUS_CTRL_HASH_EN: start with cmd_hash=1 SHALL be rejected (err pulse, stay IDLE) and hash_cipher tied 0.

Structure
REQ-028 State encoding, beat count (4), RUN cycle count (20), and rc step function SHALL live in shared package romulus_ctrl_pkg.
REQ-029 Round-constant generator SHALL be sub-module romulus_rc_gen (rc register, constant, constant2).

Verification
REQ-030 Start, in_valid always 1, out_ready 1 -> done at cycle 33 after start; sse high 8 cycles, xse/yse 4, RUN 20.
REQ-031 RUN cycle 1 -> constant=0x01, constant2=0x03; cycle 2 -> 0x07/0x0F; cycle 20 -> 0x2D/0x1A.
REQ-032 in_valid low for 3 cycles mid-LD_S -> no sse those cycles, exactly 4 beats still taken, latency 36.
REQ-033 out_ready low 5 cycles in OUT -> out_valid held, decrypt=0xF with cmd_decrypt=1, done 5 cycles later.
REQ-034 rst_n low during RUN cycle 10 -> all outputs 0 immediately; next start gives constant=0x01 in RUN cycle 1.
REQ-035 cmd_hash=1: with ROMULUS_CTRL_HASH_EN hash_cipher=1 for 20 RUN cycles; without, err pulse and busy stays 0.

Source files
------------

// File: rtl/romulus_ctrl_pkg.sv
// Shared definitions for the Romulus block controller.
//   state_t     : controller state encoding
//   BEATS       : 32-bit beats per load/unload phase
//   RUN_CYCLES  : cycles spent in RUN (two rounds per cycle)
//   rc_step     : one step of the 6-bit round-constant LFSR
package romulus_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_S  = 3'd1,
        LD_TK = 3'd2,
        RUN   = 3'd3,
        OUT   = 3'd4,
        CNT   = 3'd5
    } state_t;

    localparam int unsigned BEATS      = 4;
    localparam int unsigned RUN_CYCLES = 20;

    localparam logic [1:0] BEAT_LAST = 2'(BEATS - 1);
    localparam logic [4:0] RUN_LAST  = 5'(RUN_CYCLES - 1);

    function automatic logic [5:0] rc_step(input logic [5:0] r);
        return {r[4:0], r[5] ^ r[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/romulus_ctrl_if.sv
// Host-side handshake bundle of the Romulus block controller.
//   start/cmd_*          : block request and parameters
//   in_valid/in_ready    : pdi/sdi beat handshake
//   out_valid/out_ready  : pdo beat handshake
//   busy/done/err        : status
// Modports: master = host, slave = controller.
interface romulus_ctrl_if;

    logic       start;
    logic       cmd_decrypt;
    logic       cmd_hash;
    logic [7:0] cmd_domain;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, cmd_decrypt, cmd_hash, cmd_domain, in_valid, out_ready,
        input  in_ready, out_valid, busy, done, err
    );

    modport slave (
        input  start, cmd_decrypt, cmd_hash, cmd_domain, in_valid, out_ready,
        output in_ready, out_valid, busy, done, err
    );

endinterface

// File: rtl/romulus_rc_gen.sv
// Round-constant generator. rc is held at zero outside RUN so every block
// starts the sequence from the same point; during RUN it advances two LFSR
// steps per cycle.
//   clk, rst_n          : clock, async active-low reset
//   run                 : high in every RUN cycle
//   constant, constant2 : step(rc) and step(step(rc)) during RUN, else 0
module romulus_rc_gen
    import romulus_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic [5:0] constant,
    output logic [5:0] constant2
);

    logic [5:0] rc;
    logic [5:0] c1_raw;
    logic [5:0] c2_raw;

    assign c1_raw = rc_step(rc);
    assign c2_raw = rc_step(c1_raw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc <= '0;
        end else begin
            rc <= run ? c2_raw : 6'd0;
        end
    end

    assign constant  = run ? c1_raw : 6'd0;
    assign constant2 = run ? c2_raw : 6'd0;

endmodule

// File: rtl/romulus_ctrl.sv
// Romulus block controller: sequences state load, tweakey load, 20 double-round
// cycles, output unload and counter update for one block per start request.
//   clk, rst_n                 : clock, async active-low reset
//   bus (slave)                : start/cmd, pdi and pdo handshakes, status
//   s/x/y/z/e rst, enc, se     : datapath register controls
//   correct_cnt, tk1s          : block counter update controls
//   hash_cipher                : hash-mode cipher select
//   constant, constant2        : round constants for the two rounds of a cycle
//   domain, decrypt            : mode fields for the datapath
// Build option: ROMULUS_CTRL_HASH_EN enables hash requests; without it a start
// with cmd_hash=1 is refused with an err pulse.
//
// state | meaning
// IDLE  | waiting for start
// LD_S  | loading 4 state beats
// LD_TK | loading 4 tweakey beats
// RUN   | 20 cycles of two rounds each
// OUT   | unloading 4 output beats
// CNT   | one-cycle block counter update, then done
module romulus_ctrl
    import romulus_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    romulus_ctrl_if.slave bus,
    output logic         srst,
    output logic         senc,
    output logic         sse,
    output logic         xrst,
    output logic         xenc,
    output logic         xse,
    output logic         yrst,
    output logic         yenc,
    output logic         yse,
    output logic         zrst,
    output logic         zenc,
    output logic         zse,
    output logic         erst,
    output logic         correct_cnt,
    output logic         tk1s,
    output logic         hash_cipher,
    output logic [5:0]   constant,
    output logic [5:0]   constant2,
    output logic [7:0]   domain,
    output logic [3:0]   decrypt
);

    state_t     state, state_nxt;
    logic [1:0] beat_cnt;
    logic [4:0] run_cnt;
    logic       cap_decrypt;
    logic [7:0] cap_domain;
    logic       accept, reject, beat_adv, load_run;
    logic       in_ready_c, out_valid_c, done_c, err_c;

`ifdef ROMULUS_CTRL_HASH_EN
    logic cap_hash;
    assign reject = 1'b0;
`else
    assign reject = bus.cmd_hash;
`endif

    assign accept = (state == IDLE) && bus.start && !reject;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt    <= '0;
            run_cnt     <= '0;
            cap_decrypt <= 1'b0;
            cap_domain  <= '0;
`ifdef ROMULUS_CTRL_HASH_EN
            cap_hash    <= 1'b0;
`endif
        end else begin
            if (beat_adv) begin
                beat_cnt <= beat_cnt + 2'd1;
            end
            // down-counter: loaded on RUN entry, RUN ends at terminal count 0
            if (load_run) begin
                run_cnt <= RUN_LAST;
            end else if (state == RUN && run_cnt != 5'd0) begin
                run_cnt <= run_cnt - 5'd1;
            end
            if (accept) begin
                cap_decrypt <= bus.cmd_decrypt;
                cap_domain  <= bus.cmd_domain;
`ifdef ROMULUS_CTRL_HASH_EN
                cap_hash    <= bus.cmd_hash;
`endif
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        beat_adv    = 1'b0;
        load_run    = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        done_c      = 1'b0;
        err_c       = 1'b0;
        srst = 1'b0; senc = 1'b0; sse = 1'b0;
        xrst = 1'b0; xenc = 1'b0; xse = 1'b0;
        yrst = 1'b0; yenc = 1'b0; yse = 1'b0;
        zrst = 1'b0; zenc = 1'b0;
        erst        = 1'b0;
        correct_cnt = 1'b0;
        tk1s        = 1'b0;
        hash_cipher = 1'b0;
        decrypt     = 4'd0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (reject) begin
                        err_c = 1'b1;
                    end else begin
                        state_nxt = LD_S;
                        srst = 1'b1; xrst = 1'b1; yrst = 1'b1;
                        zrst = 1'b1; erst = 1'b1;
                    end
                end
            end
            LD_S: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    sse      = 1'b1;
                    beat_adv = 1'b1;
                    if (beat_cnt == BEAT_LAST) state_nxt = LD_TK;
                end
            end
            LD_TK: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    xse      = 1'b1;
                    yse      = 1'b1;
                    beat_adv = 1'b1;
                    if (beat_cnt == BEAT_LAST) begin
                        state_nxt = RUN;
                        load_run  = 1'b1;
                    end
                end
            end
            RUN: begin
                senc = 1'b1; xenc = 1'b1; yenc = 1'b1; zenc = 1'b1;
`ifdef ROMULUS_CTRL_HASH_EN
                hash_cipher = cap_hash;
`endif
                if (run_cnt == 5'd0) state_nxt = OUT;
            end
            OUT: begin
                out_valid_c = 1'b1;
                decrypt     = {4{cap_decrypt}};
                if (bus.out_ready) begin
                    sse      = 1'b1;
                    beat_adv = 1'b1;
                    if (beat_cnt == BEAT_LAST) state_nxt = CNT;
                end
            end
            CNT: begin
                zenc        = 1'b1;
                correct_cnt = 1'b1;
                tk1s        = cap_domain[3];
                done_c      = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign zse           = 1'b0;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.done      = done_c;
    assign bus.err       = err_c;
    assign bus.busy      = (state != IDLE);
    assign domain        = (state != IDLE) ? cap_domain : 8'd0;

    romulus_rc_gen u_rc_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (state == RUN),
        .constant  (constant),
        .constant2 (constant2)
    );

endmodule

// File: tb/tb_romulus_ctrl.sv
// Self-checking bench for romulus_ctrl. Expected round constants are queued
// from a local LFSR model when a block is started and popped in RUN cycles.
module tb_romulus_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    romulus_ctrl_if bus();

    logic srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse;
    logic zrst, zenc, zse, erst, correct_cnt, tk1s, hash_cipher;
    logic [5:0] constant, constant2;
    logic [7:0] domain;
    logic [3:0] decrypt;

    romulus_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .srst(srst), .senc(senc), .sse(sse),
        .xrst(xrst), .xenc(xenc), .xse(xse),
        .yrst(yrst), .yenc(yenc), .yse(yse),
        .zrst(zrst), .zenc(zenc), .zse(zse),
        .erst(erst), .correct_cnt(correct_cnt), .tk1s(tk1s),
        .hash_cipher(hash_cipher), .constant(constant), .constant2(constant2),
        .domain(domain), .decrypt(decrypt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed { logic [5:0] c1; logic [5:0] c2; } rc_pair_t;
    rc_pair_t exp_q[$];

    typedef struct {
        int latency; int sse_n; int xy_n; int xy_split; int run_n; int hash_n;
        int rstp_n; int err_n; int done_n; int tk_n; int cc_n; int ovs_bad;
        int sse_stall; int dom_bad; int idle_c_bad; int busy_bad; int q_left;
        logic [5:0] first_c1; logic [5:0] first_c2;
        logic [5:0] last_c1;  logic [5:0] last_c2;
    } res_t;

    function automatic logic [5:0] lfsr(input logic [5:0] r);
        return {r[4:0], ~(r[5] ^ r[4])};
    endfunction

    function automatic logic [75:0] all_outs();
        return {bus.in_ready, bus.out_valid, bus.busy, bus.done, bus.err,
                srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse,
                erst, correct_cnt, tk1s, hash_cipher, constant, constant2, domain,
                decrypt, 30'd0};
    endfunction

    // Runs one block from the current (IDLE) cycle. Cycle 0 is the start cycle.
    task automatic run_block(input logic dec, input logic hsh, input logic [7:0] dom,
                             input int in_st, input int in_len,
                             input int out_st, input int out_len,
                             input int busy_start, output res_t r);
        logic [5:0] r6;
        rc_pair_t e;
        r = '{default: 0};
        r.latency = -1;
        r6 = 6'd0;
        for (int i = 0; i < 20; i++) begin
            e.c1 = lfsr(r6);
            e.c2 = lfsr(e.c1);
            exp_q.push_back(e);
            r6 = e.c2;
        end
        bus.start = 1'b1; bus.cmd_decrypt = dec; bus.cmd_hash = hsh; bus.cmd_domain = dom;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        if (srst & xrst & yrst & zrst & erst) r.rstp_n++;
        if (bus.err) r.err_n++;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cmd_decrypt = 1'b0; bus.cmd_hash = 1'b0; bus.cmd_domain = 8'h00;
        for (int cyc = 1; cyc <= 100 && r.latency < 0; cyc++) begin
            bus.in_valid  = !(cyc >= in_st && cyc < in_st + in_len);
            bus.out_ready = !(cyc >= out_st && cyc < out_st + out_len);
            bus.start = (cyc == busy_start);
            bus.cmd_domain = (cyc == busy_start) ? ~dom : 8'h00;
            #1;
            if (sse) r.sse_n++;
            if (xse & yse) r.xy_n++;
            if (xse != yse) r.xy_split++;
            if (senc & xenc & yenc & zenc) begin
                r.run_n++;
                if (r.run_n == 1) begin r.first_c1 = constant; r.first_c2 = constant2; end
                if (r.run_n == 20) begin r.last_c1 = constant; r.last_c2 = constant2; end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if ({constant, constant2} !== {e.c1, e.c2}) begin
                        n_bad++;
                        $display("FAIL rc_run%0d got %h/%h exp %h/%h", r.run_n,
                                 constant, constant2, e.c1, e.c2);
                    end
                end
            end else if (constant != 6'd0 || constant2 != 6'd0) r.idle_c_bad++;
            if (hash_cipher) r.hash_n++;
            if (srst | xrst | yrst | zrst | erst) r.rstp_n++;
            if (bus.err) r.err_n++;
            if (tk1s) r.tk_n++;
            if (correct_cnt) r.cc_n++;
            if (!bus.in_valid && sse) r.sse_stall++;
            if (!bus.out_ready) begin
                if (!bus.out_valid || decrypt !== {4{dec}} || sse) r.ovs_bad++;
            end else if (!bus.out_valid && decrypt !== 4'd0) r.ovs_bad++;
            if (bus.out_valid && decrypt !== {4{dec}}) r.ovs_bad++;
            if (domain !== dom) r.dom_bad++;
            if (!bus.busy) r.busy_bad++;
            if (bus.done) begin r.done_n++; r.latency = cyc; end
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        if (bus.busy || bus.done || domain !== 8'd0) r.busy_bad++;
        r.q_left = exp_q.size();
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.cmd_decrypt = 1'b0; bus.cmd_hash = 1'b0; bus.cmd_domain = 8'h00;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (all_outs() !== 76'd0) begin n_bad++; $display("FAIL reset_outs got %h exp 0", all_outs()); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle busy=%b in_ready=%b exp 0/0", bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_nominal();
        res_t r;
        run_block(1'b0, 1'b0, 8'h08, 0, 0, 0, 0, 15, r);
        n_cmp++; if (r.latency !== 33) begin n_bad++; $display("FAIL nom_latency got %0d exp 33", r.latency); end
        n_cmp++; if (r.sse_n !== 8) begin n_bad++; $display("FAIL nom_sse got %0d exp 8", r.sse_n); end
        n_cmp++; if (r.xy_n !== 4 || r.xy_split !== 0) begin n_bad++; $display("FAIL nom_xyse got %0d/%0d exp 4/0", r.xy_n, r.xy_split); end
        n_cmp++; if (r.run_n !== 20) begin n_bad++; $display("FAIL nom_run got %0d exp 20", r.run_n); end
        n_cmp++; if ({r.first_c1, r.first_c2} !== {6'h01, 6'h03}) begin n_bad++; $display("FAIL nom_rc1 got %h/%h exp 01/03", r.first_c1, r.first_c2); end
        n_cmp++; if ({r.last_c1, r.last_c2} !== {6'h2D, 6'h1A}) begin n_bad++; $display("FAIL nom_rc20 got %h/%h exp 2d/1a", r.last_c1, r.last_c2); end
        n_cmp++; if (r.q_left !== 0 || r.idle_c_bad !== 0) begin n_bad++; $display("FAIL nom_rc_misc left=%0d idle_bad=%0d exp 0/0", r.q_left, r.idle_c_bad); end
        n_cmp++; if (r.rstp_n !== 1 || r.err_n !== 0) begin n_bad++; $display("FAIL nom_rst_pulse got %0d err=%0d exp 1/0", r.rstp_n, r.err_n); end
        n_cmp++; if (r.done_n !== 1 || r.cc_n !== 1 || r.tk_n !== 1) begin n_bad++; $display("FAIL nom_cnt done=%0d cc=%0d tk=%0d exp 1/1/1", r.done_n, r.cc_n, r.tk_n); end
        n_cmp++; if (r.dom_bad !== 0 || r.busy_bad !== 0) begin n_bad++; $display("FAIL nom_dom_busy dom=%0d busy=%0d exp 0/0", r.dom_bad, r.busy_bad); end
        n_cmp++; if (r.hash_n !== 0 || r.ovs_bad !== 0) begin n_bad++; $display("FAIL nom_hash_out hash=%0d ovs=%0d exp 0/0", r.hash_n, r.ovs_bad); end
    endtask

    task automatic test_in_stall();
        res_t r;
        run_block(1'b1, 1'b0, 8'h35, 3, 3, 0, 0, 0, r);
        n_cmp++; if (r.latency !== 36) begin n_bad++; $display("FAIL in_stall_latency got %0d exp 36", r.latency); end
        n_cmp++; if (r.sse_n !== 8 || r.sse_stall !== 0) begin n_bad++; $display("FAIL in_stall_sse got %0d stall=%0d exp 8/0", r.sse_n, r.sse_stall); end
        n_cmp++; if (r.xy_n !== 4 || r.tk_n !== 0) begin n_bad++; $display("FAIL in_stall_xy_tk got %0d/%0d exp 4/0", r.xy_n, r.tk_n); end
    endtask

    task automatic test_out_stall();
        res_t r;
        run_block(1'b1, 1'b0, 8'hA5, 0, 0, 30, 5, 0, r);
        n_cmp++; if (r.latency !== 38) begin n_bad++; $display("FAIL out_stall_latency got %0d exp 38", r.latency); end
        n_cmp++; if (r.ovs_bad !== 0) begin n_bad++; $display("FAIL out_stall_hold bad_cycles=%0d exp 0", r.ovs_bad); end
        n_cmp++; if (r.sse_n !== 8 || r.dom_bad !== 0) begin n_bad++; $display("FAIL out_stall_sse got %0d dom=%0d exp 8/0", r.sse_n, r.dom_bad); end
    endtask

    task automatic test_reset_mid_run();
        res_t r;
        bus.start = 1'b1; bus.cmd_decrypt = 1'b1; bus.cmd_hash = 1'b0; bus.cmd_domain = 8'hFF;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        n_cmp++;
        if (senc !== 1'b1 || constant === 6'd0) begin n_bad++; $display("FAIL mid_run_state senc=%b c=%h exp 1/nonzero", senc, constant); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (all_outs() !== 76'd0) begin n_bad++; $display("FAIL mid_run_reset got %h exp 0", all_outs()); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(1'b0, 1'b0, 8'h0F, 0, 0, 0, 0, 0, r);
        n_cmp++; if ({r.first_c1, r.first_c2} !== {6'h01, 6'h03}) begin n_bad++; $display("FAIL post_reset_rc1 got %h/%h exp 01/03", r.first_c1, r.first_c2); end
        n_cmp++; if (r.latency !== 33 || r.tk_n !== 1) begin n_bad++; $display("FAIL post_reset_block lat=%0d tk=%0d exp 33/1", r.latency, r.tk_n); end
    endtask

    task automatic test_back_to_back();
        res_t r1, r2;
        run_block(1'b0, 1'b0, 8'h11, 0, 0, 0, 0, 0, r1);
        run_block(1'b1, 1'b0, 8'h5A, 0, 0, 0, 0, 0, r2);
        n_cmp++; if (r1.latency !== 33 || r2.latency !== 33) begin n_bad++; $display("FAIL b2b_latency got %0d/%0d exp 33/33", r1.latency, r2.latency); end
        n_cmp++; if (r1.dom_bad !== 0 || r2.dom_bad !== 0 || r2.ovs_bad !== 0) begin n_bad++; $display("FAIL b2b_fields dom=%0d/%0d ovs=%0d exp 0", r1.dom_bad, r2.dom_bad, r2.ovs_bad); end
    endtask

    task automatic test_hash();
`ifdef ROMULUS_CTRL_HASH_EN
        res_t r;
        run_block(1'b0, 1'b1, 8'h20, 0, 0, 0, 0, 0, r);
        n_cmp++; if (r.hash_n !== 20 || r.err_n !== 0) begin n_bad++; $display("FAIL hash_cipher got %0d err=%0d exp 20/0", r.hash_n, r.err_n); end
        n_cmp++; if (r.latency !== 33) begin n_bad++; $display("FAIL hash_latency got %0d exp 33", r.latency); end
`else
        res_t r;
        bus.start = 1'b1; bus.cmd_hash = 1'b1; bus.cmd_decrypt = 1'b0; bus.cmd_domain = 8'h20;
        #1;
        n_cmp++;
        if (bus.err !== 1'b1 || srst !== 1'b0) begin n_bad++; $display("FAIL hash_reject err=%b srst=%b exp 1/0", bus.err, srst); end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cmd_hash = 1'b0;
        #1;
        n_cmp++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL hash_err_pulse err=%b busy=%b exp 0/0", bus.err, bus.busy); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL hash_stay_idle busy=%b in_ready=%b exp 0/0", bus.busy, bus.in_ready); end
        run_block(1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, r);
        n_cmp++; if (r.latency !== 33 || r.hash_n !== 0) begin n_bad++; $display("FAIL hash_after_reject lat=%0d hash=%0d exp 33/0", r.latency, r.hash_n); end
`endif
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_in_stall();
        test_out_stall();
        test_reset_mid_run();
        test_back_to_back();
        test_hash();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
